// File: rtl/branch_pkg.sv
// Shared definitions for the branch target unit.
// Contents:
//   br_mode_e   - target mode encoding (REL, ABS, IND, FALL)
//   OFFSET_W    - width of the offset/immediate operand
//   entry_width - width of one packed queue entry {target, tag, wrap}
package branch_pkg;

    typedef enum logic [1:0] {
        BR_REL  = 2'b00,
        BR_ABS  = 2'b01,
        BR_IND  = 2'b10,
        BR_FALL = 2'b11
    } br_mode_e;

    localparam int OFFSET_W = 32;

    // Queue entries are packed as {target[pc_w], tag[tag_w], wrap}.
    function automatic int entry_width(input int pc_w, input int tag_w);
        return pc_w + tag_w + 1;
    endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational branch target generator.
// Ports:
//   mode       - target mode (br_mode_e encoding)
//   pc_next    - fall-through PC
//   pc_branch  - signed offset (REL) or absolute target (ABS)
//   reg_target - register-indirect target
//   target     - computed target, truncated to PC_WIDE bits
//   wrap       - the untruncated target lies outside the PC range
module branch_target_calc
    import branch_pkg::*;
#(
    parameter int PC_WIDE = 7
) (
    input  logic [1:0]          mode,
    input  logic [PC_WIDE-1:0]  pc_next,
    input  logic [OFFSET_W-1:0] pc_branch,
    input  logic [PC_WIDE-1:0]  reg_target,
    output logic [PC_WIDE-1:0]  target,
    output logic                wrap
);

    // Two guard bits above the offset width hold the full range of
    // unsigned PC plus signed 32-bit offset without overflow; any set bit
    // at or above PC_WIDE (including the sign) means the target wrapped.
    localparam int SUM_W = OFFSET_W + 2;

    logic [SUM_W-1:0] sum_s;

    assign sum_s = {{(SUM_W - PC_WIDE){1'b0}}, pc_next}
                 + {{(SUM_W - OFFSET_W){pc_branch[OFFSET_W-1]}}, pc_branch};

    // Mode mux selecting the target and its range-violation flag.
    always_comb begin
        target = {PC_WIDE{1'b0}};
        wrap   = 1'b0;
        case (mode)
            BR_REL: begin
                target = sum_s[PC_WIDE-1:0];
                wrap   = |sum_s[SUM_W-1:PC_WIDE];
            end
            BR_ABS: begin
                target = pc_branch[PC_WIDE-1:0];
                wrap   = |pc_branch[OFFSET_W-1:PC_WIDE];
            end
            BR_IND: begin
                target = reg_target;
                wrap   = 1'b0;
            end
            BR_FALL: begin
                target = pc_next;
                wrap   = 1'b0;
            end
            default: begin
                target = {PC_WIDE{1'b0}};
                wrap   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/branch_target_unit.sv
// Pipelined branch target unit for the fetch stage. Targets are computed at
// accept time and stored in a small FIFO; the head entry drives registered
// outputs one cycle after acceptance.
// Ports:
//   clk, rst            - clock; asynchronous active-low reset
//   flush               - drop all queued entries and the incoming request
//   in_valid/in_ready   - request handshake (in_ready is registered)
//   in_mode, pc_next, pc_branch, reg_target, in_tag - request fields
//   out_valid/out_ready - result handshake
//   branch_pc, out_tag, out_wrap - head entry (held while out_valid=0)
module branch_target_unit
    import branch_pkg::*;
#(
    parameter int PC_WIDE = 7,
    parameter int TAG_W   = 3,
    parameter int DEPTH   = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_mode,
    input  logic [PC_WIDE-1:0]  pc_next,
    input  logic [OFFSET_W-1:0] pc_branch,
    input  logic [PC_WIDE-1:0]  reg_target,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PC_WIDE-1:0]  branch_pc,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_wrap
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = entry_width(PC_WIDE, TAG_W);

    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;

    logic [PTR_W-1:0]   rd_ptr_nxt_s;
    logic [PTR_W-1:0]   wr_ptr_nxt_s;
    logic [CNT_W-1:0]   count_nxt_s;
    logic               push_s;
    logic               pop_s;
    logic [PC_WIDE-1:0] calc_target_s;
    logic               calc_wrap_s;
    logic [ENTRY_W-1:0] new_entry_s;
    logic [ENTRY_W-1:0] head_entry_s;

    branch_target_calc #(
        .PC_WIDE (PC_WIDE)
    ) u_calc (
        .mode       (in_mode),
        .pc_next    (pc_next),
        .pc_branch  (pc_branch),
        .reg_target (reg_target),
        .target     (calc_target_s),
        .wrap       (calc_wrap_s)
    );

    // in_ready and out_valid are registers, so neither handshake has a
    // combinational path from the opposite side.
    assign push_s      = in_valid & in_ready & ~flush;
    assign pop_s       = out_valid & out_ready & ~flush;
    assign new_entry_s = {calc_target_s, in_tag, calc_wrap_s};

    // Next pointer/count state; flush overrides accept and pop.
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        wr_ptr_nxt_s = wr_ptr_r;
        count_nxt_s  = count_r;
        if (flush) begin
            rd_ptr_nxt_s = {PTR_W{1'b0}};
            wr_ptr_nxt_s = {PTR_W{1'b0}};
            count_nxt_s  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end
            if (push_s && !pop_s) begin
                count_nxt_s = count_r + CNT_ONE;
            end else if (pop_s && !push_s) begin
                count_nxt_s = count_r - CNT_ONE;
            end else begin
                count_nxt_s = count_r;
            end
        end
    end

    // The next head is the entry being written this edge when it lands
    // exactly at the next read pointer (empty queue, or push+pop at
    // count 1); otherwise it is already in storage.
    always_comb begin
        head_entry_s = mem_r[rd_ptr_nxt_s];
        if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_entry_s = new_entry_s;
        end else begin
            head_entry_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Entry storage written on accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_r] <= new_entry_s;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers, occupancy and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_r  <= {PTR_W{1'b0}};
            wr_ptr_r  <= {PTR_W{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            branch_pc <= {PC_WIDE{1'b0}};
            out_tag   <= {TAG_W{1'b0}};
            out_wrap  <= 1'b0;
        end else begin
            rd_ptr_r  <= rd_ptr_nxt_s;
            wr_ptr_r  <= wr_ptr_nxt_s;
            count_r   <= count_nxt_s;
            in_ready  <= (count_nxt_s < CNT_DEPTH);
            out_valid <= (count_nxt_s != {CNT_W{1'b0}});
            if (count_nxt_s != {CNT_W{1'b0}}) begin
                branch_pc <= head_entry_s[ENTRY_W-1 -: PC_WIDE];
                out_tag   <= head_entry_s[TAG_W:1];
                out_wrap  <= head_entry_s[0];
            end else begin
                branch_pc <= branch_pc;
                out_tag   <= out_tag;
                out_wrap  <= out_wrap;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_unit.sv
// Directed self-checking bench for branch_target_unit (PC_WIDE=7, DEPTH=2).
module tb_branch_target_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [6:0]  pc_next;
    logic [31:0] pc_branch;
    logic [6:0]  reg_target;
    logic [2:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  branch_pc;
    logic [2:0]  out_tag;
    logic        out_wrap;

    int checks   = 0;
    int failures = 0;

    branch_target_unit #(
        .PC_WIDE (7),
        .TAG_W   (3),
        .DEPTH   (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .pc_next    (pc_next),
        .pc_branch  (pc_branch),
        .reg_target (reg_target),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .branch_pc  (branch_pc),
        .out_tag    (out_tag),
        .out_wrap   (out_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [1:0] m, input logic [6:0] pcn,
                             input logic [31:0] pcb, input logic [6:0] rt,
                             input logic [2:0] tg);
        in_valid   = 1'b1;
        in_mode    = m;
        pc_next    = pcn;
        pc_branch  = pcb;
        reg_target = rt;
        in_tag     = tg;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs out_valid=%b in_ready=%b expected 0/0", out_valid, in_ready);
        end
        checks++;
        if (branch_pc !== 7'd0 || out_tag !== 3'd0 || out_wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset_data pc=%0d tag=%0d wrap=%b expected 0/0/0", branch_pc, out_tag, out_wrap);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b0;
        drive_req(2'b00, 7'd10, 32'd5, 7'd0, 3'd0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || branch_pc !== 7'd15 || out_wrap !== 1'b0) begin
            failures++;
            $display("FAIL basic_rel v=%b pc=%0d wrap=%b expected 1/15/0", out_valid, branch_pc, out_wrap);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_pop out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_wrap();
        logic [6:0]  pcn [3] = '{7'd120, 7'd3, 7'd20};
        logic [31:0] pcb [3] = '{32'd10, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
        logic [6:0]  exp_pc [3] = '{7'd2, 7'd126, 7'd15};
        logic        exp_w [3] = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b0;
            drive_req(2'b00, pcn[i], pcb[i], 7'd0, 3'(i));
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || branch_pc !== exp_pc[i] || out_wrap !== exp_w[i]) begin
                failures++;
                $display("FAIL wrap_%0d v=%b pc=%0d wrap=%b expected 1/%0d/%b",
                         i, out_valid, branch_pc, out_wrap, exp_pc[i], exp_w[i]);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    // Streaming with out_ready=1 exercises push+pop at count 1 each cycle.
    task automatic test_modes();
        logic [1:0]  m   [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        logic [6:0]  pcn [4] = '{7'd10, 7'd0, 7'd0, 7'd40};
        logic [31:0] pcb [4] = '{32'd5, 32'h85, 32'd0, 32'd0};
        logic [6:0]  rt  [4] = '{7'd0, 7'd0, 7'd77, 7'd0};
        logic [6:0]  exp_pc [4] = '{7'd15, 7'd5, 7'd77, 7'd40};
        logic        exp_w [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_req(m[i], pcn[i], pcb[i], rt[i], 3'(i + 1));
            tick();
            checks++;
            if (out_valid !== 1'b1 || branch_pc !== exp_pc[i] || out_wrap !== exp_w[i]
                || out_tag !== 3'(i + 1) || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL mode_%0d v=%b pc=%0d wrap=%b tag=%0d rdy=%b expected 1/%0d/%b/%0d/1",
                         i, out_valid, branch_pc, out_wrap, out_tag, in_ready,
                         exp_pc[i], exp_w[i], i + 1);
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mode_drain out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive_req(2'b00, 7'd0, 32'd1, 7'd0, 3'd5);
        tick();
        drive_req(2'b00, 7'd0, 32'd2, 7'd0, 3'd6);
        tick();
        checks++;
        if (in_ready !== 1'b0 || out_tag !== 3'd5) begin
            failures++;
            $display("FAIL bp_full in_ready=%b tag=%0d expected 0/5", in_ready, out_tag);
        end
        drive_req(2'b00, 7'd0, 32'd3, 7'd0, 3'd7);
        tick();
        checks++;
        if (in_ready !== 1'b0 || branch_pc !== 7'd1 || out_tag !== 3'd5) begin
            failures++;
            $display("FAIL bp_hold in_ready=%b pc=%0d tag=%0d expected 0/1/5", in_ready, branch_pc, out_tag);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || branch_pc !== 7'd2 || out_tag !== 3'd6) begin
            failures++;
            $display("FAIL bp_pop1 rdy=%b v=%b pc=%0d tag=%0d expected 1/1/2/6", in_ready, out_valid, branch_pc, out_tag);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || branch_pc !== 7'd3 || out_tag !== 3'd7) begin
            failures++;
            $display("FAIL bp_third v=%b pc=%0d tag=%0d expected 1/3/7", out_valid, branch_pc, out_tag);
        end
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive_req(2'b11, 7'd11, 32'd0, 7'd0, 3'd1);
        tick();
        drive_req(2'b11, 7'd12, 32'd0, 7'd0, 3'd2);
        tick();
        drive_req(2'b11, 7'd13, 32'd0, 7'd0, 3'd3);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_state v=%b rdy=%b expected 0/1", out_valid, in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_ghost out_valid=%b expected 0", out_valid);
        end
        drive_req(2'b11, 7'd40, 32'd0, 7'd0, 3'd4);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || branch_pc !== 7'd40 || out_tag !== 3'd4) begin
            failures++;
            $display("FAIL flush_after v=%b pc=%0d tag=%0d expected 1/40/4", out_valid, branch_pc, out_tag);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive_req(2'b00, 7'd10, 32'd5, 7'd0, 3'd1);
        tick();
        drive_req(2'b00, 7'd20, 32'd5, 7'd0, 3'd2);
        tick();
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || branch_pc !== 7'd0 || out_tag !== 3'd0) begin
            failures++;
            $display("FAIL async_rst v=%b rdy=%b pc=%0d tag=%0d expected 0/0/0/0", out_valid, in_ready, branch_pc, out_tag);
        end
        @(negedge clk);
        rst = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL async_release v=%b rdy=%b expected 0/1", out_valid, in_ready);
        end
        drive_req(2'b00, 7'd120, 32'd10, 7'd0, 3'd6);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || branch_pc !== 7'd2 || out_wrap !== 1'b1 || out_tag !== 3'd6) begin
            failures++;
            $display("FAIL async_next v=%b pc=%0d wrap=%b tag=%0d expected 1/2/1/6", out_valid, branch_pc, out_wrap, out_tag);
        end
    endtask

    initial begin
        rst        = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_mode    = 2'b00;
        pc_next    = 7'd0;
        pc_branch  = 32'd0;
        reg_target = 7'd0;
        in_tag     = 3'd0;
        out_ready  = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_modes();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
